// File: rtl/shift_iter_unit.sv
// shift_iter_unit: iterative shifter moving up to STEP bits per cycle; define SHIFT_ITER_ROTATE_EN to support ROL (op 11)
module shift_iter_unit #(
  parameter int WIDTH = 32,
  parameter int STEP = 4,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [SHW-1:0]   i_shamt,
  input  logic [1:0]       i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_err
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [SHW-1:0] STEP_W = SHW'(STEP);
  state_t state, state_nx;
  logic [WIDTH-1:0] data, data_sh, sra, rol;
  logic [SHW-1:0] rem, s;
  logic [1:0] op;
  logic err, unsup;
`ifdef SHIFT_ITER_ROTATE_EN
  assign unsup = 1'b0;
  assign rol = (data << s) | (data >> (WIDTH - int'(s)));
`else
  assign unsup = i_op == 2'b11;
  assign rol = data;
`endif
  assign s = rem < STEP_W ? rem : STEP_W;
  assign sra = $signed(data) >>> s;
  assign data_sh = op == 2'b00 ? data << s : op == 2'b01 ? data >> s : op == 2'b10 ? sra : rol;
  assign o_ready = state == IDLE;
  always_comb begin
    state_nx = state;
    if (i_flush) state_nx = IDLE;
    else if (state == IDLE) state_nx = !i_valid ? IDLE : (i_shamt == '0 || unsup) ? DONE : SHIFT;
    else if (state == SHIFT) state_nx = rem == s ? DONE : SHIFT;
    else state_nx = (o_valid && i_ready) ? IDLE : DONE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      data <= '0;
      rem <= '0;
      op <= '0;
      err <= 1'b0;
      o_valid <= 1'b0;
      o_result <= '0;
      o_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (i_flush) begin
        rem <= '0;
        o_valid <= 1'b0;
      end else if (state == IDLE && i_valid) begin
        data <= unsup ? '0 : i_a;
        rem <= unsup ? '0 : i_shamt;
        op <= i_op;
        err <= unsup;
      end else if (state == SHIFT) begin
        data <= data_sh;
        rem <= rem - s;
      end else if (state == DONE) begin
        o_valid <= !(o_valid && i_ready);
        if (!o_valid) begin
          o_result <= data;
          o_err <= err;
        end
      end
    end
  end
endmodule

// File: tb/tb_shift_iter_unit.sv
// tb_shift_iter_unit: vector table, directed corner sequences and random ops against an arithmetic model
module tb_shift_iter_unit;
  logic i_clk = 0, i_rst_n = 0, i_flush = 0, i_valid = 0, i_ready = 1;
  logic o_ready, o_valid, o_err;
  logic [31:0] i_a = 0, o_result;
  logic [4:0] i_shamt = 0;
  logic [1:0] i_op = 0;
  int checks = 0, failures = 0;

  shift_iter_unit #(.WIDTH(32), .STEP(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_shamt(i_shamt), .i_op(i_op), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  sh;
    logic [1:0]  op;
    logic [31:0] r;
    logic        e;
    int          lat;
  } vec_t;
  vec_t vt[10];

`ifdef SHIFT_ITER_ROTATE_EN
  localparam bit ROT = 1;
`else
  localparam bit ROT = 0;
`endif

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] a, input int sh, input logic [1:0] op);
    logic [63:0] w;
    case (op)
      2'b00: return {1'b0, a << sh};
      2'b01: return {1'b0, a >> sh};
      2'b10: begin w = {{32{a[31]}}, a}; return {1'b0, w[sh +: 32]}; end
      default: begin
        if (!ROT) return {1'b1, 32'h0};
        w = {a, a} << sh;
        return {1'b0, w[63:32]};
      end
    endcase
  endfunction

  function automatic int model_lat(input int sh, input logic [1:0] op);
    return (op == 2'b11 && !ROT) ? 1 : (sh + 3) / 4 + 1;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] op,
                        output logic [31:0] r, output logic e, output int lat);
    int n = 0;
    while (!o_ready && n < 50) begin tick; n++; end
    i_a = a; i_shamt = sh; i_op = op; i_valid = 1; i_ready = 1;
    tick;
    i_valid = 0;
    lat = -1; r = 0; e = 0;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (o_valid) begin lat = c; r = o_result; e = o_err; break; end
    end
    tick;
  endtask

  initial begin
    logic [31:0] r;
    logic e;
    int lat, seen;
    logic [32:0] m;
    vt[0] = '{32'h0000_0001, 5'd13, 2'b00, 32'h0000_2000, 1'b0, 5};
    vt[1] = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b0, 9};
    vt[2] = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 1'b0, 9};
    vt[3] = '{32'h8000_0001, 5'd4,  2'b11, ROT ? 32'h0000_0018 : 32'h0, !ROT, ROT ? 2 : 1};
    vt[4] = '{32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF, 1'b0, 1};
    vt[5] = '{32'hF0F0_F0F0, 5'd8,  2'b10, 32'hFFF0_F0F0, 1'b0, 3};
    vt[6] = '{32'h1234_5678, 5'd4,  2'b01, 32'h0123_4567, 1'b0, 2};
    vt[7] = '{32'h1234_5678, 5'd16, 2'b00, 32'h5678_0000, 1'b0, 5};
    vt[8] = '{32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000, 1'b0, 9};
    vt[9] = '{32'h1234_5678, 5'd8,  2'b11, ROT ? 32'h3456_7812 : 32'h0, !ROT, ROT ? 3 : 1};

    #3;
    chk("reset_valid", 64'(o_valid), 64'(0));
    chk("reset_result", 64'(o_result), 64'(0));
    chk("reset_err", 64'(o_err), 64'(0));
    #4 i_rst_n = 1;
    tick;
    chk("ready_after_reset", 64'(o_ready), 64'(1));

    foreach (vt[i]) begin
      run_op(vt[i].a, vt[i].sh, vt[i].op, r, e, lat);
      chk($sformatf("vec%0d_result", i), 64'(r), 64'(vt[i].r));
      chk($sformatf("vec%0d_err", i), 64'(e), 64'(vt[i].e));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
    end

    // backpressure: result held while the consumer stalls, new requests ignored
    i_ready = 0; i_a = 32'hDEAD_BEEF; i_shamt = 0; i_op = 2'b00; i_valid = 1;
    tick;
    i_valid = 0;
    tick;
    chk("bp_valid", 64'(o_valid), 64'(1));
    chk("bp_result", 64'(o_result), 64'hDEAD_BEEF);
    i_valid = 1; i_a = 32'h1111_1111; i_shamt = 5'd3;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("bp_hold_valid", 64'(o_valid), 64'(1));
      chk("bp_hold_result", 64'(o_result), 64'hDEAD_BEEF);
      chk("bp_hold_ready", 64'(o_ready), 64'(0));
    end
    i_valid = 0; i_ready = 1;
    tick;
    chk("bp_release_valid", 64'(o_valid), 64'(0));
    chk("bp_release_ready", 64'(o_ready), 64'(1));
    tick;
    chk("bp_ignored_req", 64'(o_valid), 64'(0));

    // flush in the second SHIFT cycle
    i_a = 32'h0000_00FF; i_shamt = 5'd20; i_op = 2'b00; i_valid = 1;
    tick;
    i_valid = 0;
    tick;
    i_flush = 1;
    tick;
    i_flush = 0;
    chk("flush_idle", 64'(o_ready), 64'(1));
    seen = 0;
    for (int c = 0; c < 10; c++) begin tick; seen |= int'(o_valid); end
    chk("flush_no_valid", 64'(seen), 64'(0));
    run_op(32'h0000_00FF, 5'd20, 2'b00, r, e, lat);
    chk("after_flush_result", 64'(r), 64'hFF0_0000);
    chk("after_flush_latency", 64'(lat), 64'(6));

    // flush together with valid in IDLE: not accepted
    i_valid = 1; i_flush = 1; i_shamt = 0;
    tick;
    i_valid = 0; i_flush = 0;
    tick;
    chk("flush_wins_valid", 64'(o_valid), 64'(0));
    chk("flush_wins_ready", 64'(o_ready), 64'(1));

    // async reset mid-SHIFT
    i_a = 32'hCAFE_0001; i_shamt = 5'd28; i_op = 2'b01; i_valid = 1;
    tick;
    i_valid = 0;
    tick; tick;
    #2 i_rst_n = 0;
    #1;
    chk("rst_mid_valid", 64'(o_valid), 64'(0));
    chk("rst_mid_result", 64'(o_result), 64'(0));
    chk("rst_mid_err", 64'(o_err), 64'(0));
    chk("rst_mid_ready", 64'(o_ready), 64'(1));
    #3 i_rst_n = 1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin tick; seen |= int'(o_valid); end
    chk("rst_no_valid", 64'(seen), 64'(0));

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      logic [4:0] sh;
      logic [1:0] op;
      a = $urandom;
      sh = 5'($urandom_range(0, 31));
      op = 2'($urandom_range(0, 3));
      m = model(a, int'(sh), op);
      run_op(a, sh, op, r, e, lat);
      chk($sformatf("rnd%0d_result", i), 64'(r), 64'(m[31:0]));
      chk($sformatf("rnd%0d_err", i), 64'(e), 64'(m[32]));
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(model_lat(int'(sh), op)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
